uart_rx: RTL and testbench

Serial receiver that sits directly downstream of the transmit datapath/state-machine pair. It recovers 7-bit characters from the single-line serial stream driven on `dout`, using the same frame format and parity selection. It delivers each character with a one-cycle valid strobe and parity/framing error flags. It oversamples the line with the system clock, so no separate baud clock is needed.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 7-bit UART receive path: character width,
// receiver state encoding and parity-sense constants.
package uart_pkg;

    localparam int DATA_W = 7;

    localparam logic PAR_EVEN = 1'b1;
    localparam logic PAR_ODD  = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // True when the received parity bit disagrees with the selected sense.
    function automatic logic parity_mismatch(input logic [DATA_W-1:0] data,
                                             input logic              pbit,
                                             input logic              sense);
        logic expected_xor;
        case (sense)
            PAR_EVEN: expected_xor = 1'b0;
            PAR_ODD:  expected_xor = 1'b1;
            default:  expected_xor = 1'b1;
        endcase
        return (((^data) ^ pbit) != expected_xor);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector; all flops reset to the idle-high line level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxd_s,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain and one-cycle history for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= rxd;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rxd_s = r_sync;
    assign fall  = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver for 7-bit characters with parity/framing flags.
// Build option: define UART_RX_PARITY_EN to include and check the parity bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    input  logic              p_s,
    output logic [DATA_W-1:0] din,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int              HALF     = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] N_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_W - 1);

    logic w_rxd_s;
    logic w_fall;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .rxd_s (w_rxd_s),
        .fall  (w_fall)
    );

    rx_state_t         r_state,  w_state_nxt;
    logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;
    logic [2:0]        r_idx,    w_idx_nxt;
    logic [DATA_W-1:0] r_shift,  w_shift_nxt;
    logic              r_wait_high, w_wait_nxt;
    logic [DATA_W-1:0] r_din,    w_din_nxt;
    logic              r_valid,  w_valid_nxt;
    logic              r_frame_err, w_ferr_nxt;
    logic              r_busy,   w_busy_nxt;
    logic              w_tick;

`ifdef UART_RX_PARITY_EN
    logic              r_psel,   w_psel_nxt;
    logic              r_perr,   w_perr_nxt;
    logic              r_parity_err, w_perr_out_nxt;
`else
    logic              w_unused_p_s;
    assign w_unused_p_s = p_s;
`endif

    assign w_tick = (r_cnt == ((r_state == START) ? H_LAST : N_LAST));

    // Next-state, sampling and output-strobe logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_wait_nxt  = r_wait_high;
        w_din_nxt   = r_din;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_psel_nxt     = r_psel;
        w_perr_nxt     = r_perr;
        w_perr_out_nxt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_cnt_nxt = {CNT_W{1'b0}};
                w_idx_nxt = 3'd0;
                // After a break, the line must be seen high before re-arming.
                if (r_wait_high) begin
                    if (w_rxd_s) begin
                        w_wait_nxt = 1'b0;
                    end else begin
                        w_wait_nxt = 1'b1;
                    end
                end else if (w_fall) begin
                    w_state_nxt = START;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                if (w_tick) begin
                    w_cnt_nxt = {CNT_W{1'b0}};
                    if (!w_rxd_s) begin
                        w_state_nxt = DATA;
`ifdef UART_RX_PARITY_EN
                        w_psel_nxt  = p_s;
`endif
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_shift_nxt = {w_rxd_s, r_shift[DATA_W-1:1]};
                    if (r_idx == IDX_LAST) begin
                        w_idx_nxt = 3'd0;
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (w_tick) begin
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_perr_nxt  = parity_mismatch(r_shift, w_rxd_s, r_psel);
                    w_state_nxt = STOP;
                end else begin
                    w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
`else
                w_state_nxt = IDLE;
`endif
            end
            STOP: begin
                if (w_tick) begin
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_din_nxt   = r_shift;
                    w_valid_nxt = 1'b1;
                    w_ferr_nxt  = ~w_rxd_s;
                    w_wait_nxt  = ~w_rxd_s;
                    w_state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                    w_perr_out_nxt = r_perr;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_idx_nxt   = 3'd0;
            end
        endcase
        // Busy stays up through the valid cycle and drops on the next edge.
        w_busy_nxt = (w_state_nxt != IDLE) | w_valid_nxt;
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_idx       <= 3'd0;
            r_shift     <= {DATA_W{1'b0}};
            r_wait_high <= 1'b0;
            r_din       <= {DATA_W{1'b0}};
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_psel       <= PAR_EVEN;
            r_perr       <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_wait_high <= w_wait_nxt;
            r_din       <= w_din_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_ferr_nxt;
            r_busy      <= w_busy_nxt;
`ifdef UART_RX_PARITY_EN
            r_psel       <= w_psel_nxt;
            r_perr       <= w_perr_nxt;
            r_parity_err <= w_perr_out_nxt;
`endif
        end
    end

    assign din       = r_din;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives serial frames bit by bit and
// compares delivered characters, flags and timing against a frame-level model.
module tb_uart_rx;

    localparam int N = 16;
    localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME_BITS = PAR_EN ? 10 : 9;
    localparam int LAT        = 2 + H + (FRAME_BITS - 1) * N;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       p_s;
    logic [6:0] din;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         ev_cyc[$];
    logic [6:0] ev_din[$];
    logic       ev_perr[$];
    logic       ev_ferr[$];

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .p_s        (p_s),
        .din        (din),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            ev_cyc.push_back(cyc);
            ev_din.push_back(din);
            ev_perr.push_back(parity_err);
            ev_ferr.push_back(frame_err);
        end
    end

    function automatic int ones(input logic [6:0] d, input logic pbit);
        int n = 0;
        for (int i = 0; i < 7; i++) n = n + int'(d[i]);
        return n + int'(pbit);
    endfunction

    // Parity bit a correct transmitter would send.
    function automatic logic good_pbit(input logic [6:0] d, input logic even);
        int k = ones(d, 1'b0) % 2;
        return even ? logic'(k == 1) : logic'(k == 0);
    endfunction

    function automatic logic exp_perr(input logic [6:0] d, input logic pbit, input logic even);
        int k = ones(d, pbit) % 2;
        if (!PAR_EN) return 1'b0;
        return even ? logic'(k != 0) : logic'(k != 1);
    endfunction

    task automatic clear_events();
        ev_cyc.delete();
        ev_din.delete();
        ev_perr.delete();
        ev_ferr.delete();
    endtask

    // Called at a falling clock edge; returns at a falling edge after the stop bit.
    task automatic send_frame(input logic [6:0] d, input logic pbit, input logic stop,
                              input logic ps_mid, output int t0);
        t0  = cyc + 1;
        rxd = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            if (i == 4) p_s = ps_mid;
            rxd = d[i];
            repeat (N) @(negedge clk);
        end
        if (PAR_EN) begin
            rxd = pbit;
            repeat (N) @(negedge clk);
        end
        rxd = stop;
        repeat (N) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rxd = 1'b1;
        p_s = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (din !== 7'h00) begin bad++; $display("FAIL reset_din got=%h want=00", din); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_err); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", parity_err); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_even_parity();
        int t0;
        clear_events();
        p_s = 1'b1;
        send_frame(7'h03, 1'b0, 1'b1, 1'b1, t0);
        rxd = 1'b1;
        repeat (2 * N) @(negedge clk);
        total++; if (ev_cyc.size() !== 1) begin bad++; $display("FAIL even_count got=%0d want=1", ev_cyc.size()); end
        if (ev_cyc.size() > 0) begin
            total++; if (ev_cyc[0] !== t0 + LAT) begin bad++; $display("FAIL even_latency got=%0d want=%0d", ev_cyc[0] - t0, LAT); end
            total++; if (ev_din[0] !== 7'h03) begin bad++; $display("FAIL even_din got=%h want=03", ev_din[0]); end
            total++; if (ev_perr[0] !== 1'b0) begin bad++; $display("FAIL even_perr got=%b want=0", ev_perr[0]); end
            total++; if (ev_ferr[0] !== 1'b0) begin bad++; $display("FAIL even_ferr got=%b want=0", ev_ferr[0]); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL even_busy_idle got=%b want=0", busy); end
    endtask

    task automatic test_odd_wrong();
        int t0;
        clear_events();
        p_s = 1'b0;
        send_frame(7'h03, 1'b0, 1'b1, 1'b0, t0);
        rxd = 1'b1;
        repeat (2 * N) @(negedge clk);
        total++; if (ev_cyc.size() !== 1) begin bad++; $display("FAIL odd_count got=%0d want=1", ev_cyc.size()); end
        if (ev_cyc.size() > 0) begin
            total++; if (ev_din[0] !== 7'h03) begin bad++; $display("FAIL odd_din got=%h want=03", ev_din[0]); end
            total++; if (ev_perr[0] !== exp_perr(7'h03, 1'b0, 1'b0)) begin bad++; $display("FAIL odd_perr got=%b want=%b", ev_perr[0], exp_perr(7'h03, 1'b0, 1'b0)); end
            total++; if (ev_ferr[0] !== 1'b0) begin bad++; $display("FAIL odd_ferr got=%b want=0", ev_ferr[0]); end
        end
    endtask

    task automatic test_glitch();
        int busy_cnt = 0;
        clear_events();
        rxd = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) rxd = 1'b1;
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
        end
        total++; if (busy_cnt !== H) begin bad++; $display("FAIL glitch_busy_cycles got=%0d want=%0d", busy_cnt, H); end
        total++; if (ev_cyc.size() !== 0) begin bad++; $display("FAIL glitch_valid got=%0d want=0", ev_cyc.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_break();
        int t0;
        clear_events();
        p_s = 1'b1;
        send_frame(7'h55, good_pbit(7'h55, 1'b1), 1'b0, 1'b1, t0);
        repeat (40) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * N) @(negedge clk);
        total++; if (ev_cyc.size() !== 1) begin bad++; $display("FAIL break_count got=%0d want=1", ev_cyc.size()); end
        if (ev_cyc.size() > 0) begin
            total++; if (ev_din[0] !== 7'h55) begin bad++; $display("FAIL break_din got=%h want=55", ev_din[0]); end
            total++; if (ev_ferr[0] !== 1'b1) begin bad++; $display("FAIL break_ferr got=%b want=1", ev_ferr[0]); end
            total++; if (ev_perr[0] !== 1'b0) begin bad++; $display("FAIL break_perr got=%b want=0", ev_perr[0]); end
        end
    endtask

    task automatic test_back_to_back();
        int t0a;
        int t0b;
        clear_events();
        p_s = 1'b1;
        send_frame(7'h55, good_pbit(7'h55, 1'b1), 1'b1, 1'b1, t0a);
        send_frame(7'h2A, good_pbit(7'h2A, 1'b1), 1'b1, 1'b1, t0b);
        rxd = 1'b1;
        repeat (2 * N) @(negedge clk);
        total++; if (ev_cyc.size() !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", ev_cyc.size()); end
        if (ev_cyc.size() > 1) begin
            total++; if (ev_cyc[1] - ev_cyc[0] !== FRAME_BITS * N) begin bad++; $display("FAIL b2b_spacing got=%0d want=%0d", ev_cyc[1] - ev_cyc[0], FRAME_BITS * N); end
            total++; if (ev_din[0] !== 7'h55) begin bad++; $display("FAIL b2b_din0 got=%h want=55", ev_din[0]); end
            total++; if (ev_din[1] !== 7'h2A) begin bad++; $display("FAIL b2b_din1 got=%h want=2a", ev_din[1]); end
            total++; if ((ev_perr[0] | ev_perr[1] | ev_ferr[0] | ev_ferr[1]) !== 1'b0) begin bad++; $display("FAIL b2b_flags got=%b%b%b%b want=0000", ev_perr[0], ev_perr[1], ev_ferr[0], ev_ferr[1]); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            int         t0;
            logic [6:0] d;
            logic       ps;
            logic       pbit;
            logic       stop;
            logic       ps_mid;
            d      = 7'($urandom_range(0, 127));
            ps     = 1'($urandom_range(0, 1));
            pbit   = 1'($urandom_range(0, 1));
            stop   = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            ps_mid = 1'($urandom_range(0, 1));
            clear_events();
            p_s = ps;
            send_frame(d, pbit, stop, ps_mid, t0);
            rxd = 1'b1;
            repeat (2 * N) @(negedge clk);
            total++; if (ev_cyc.size() !== 1) begin bad++; $display("FAIL rand%0d_count got=%0d want=1", k, ev_cyc.size()); end
            if (ev_cyc.size() > 0) begin
                total++; if (ev_cyc[0] !== t0 + LAT) begin bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", k, ev_cyc[0] - t0, LAT); end
                total++; if (ev_din[0] !== d) begin bad++; $display("FAIL rand%0d_din got=%h want=%h", k, ev_din[0], d); end
                total++; if (ev_perr[0] !== exp_perr(d, pbit, ps)) begin bad++; $display("FAIL rand%0d_perr got=%b want=%b", k, ev_perr[0], exp_perr(d, pbit, ps)); end
                total++; if (ev_ferr[0] !== ~stop) begin bad++; $display("FAIL rand%0d_ferr got=%b want=%b", k, ev_ferr[0], ~stop); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int t0;
        clear_events();
        p_s = 1'b1;
        rxd = 1'b0;
        repeat (N) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * N) @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if ({din, valid, busy, frame_err, parity_err} !== 11'd0) begin bad++; $display("FAIL midrst_outputs got=%h/%b%b%b%b want=0", din, valid, busy, frame_err, parity_err); end
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3 * N) @(negedge clk);
        total++; if (ev_cyc.size() !== 0) begin bad++; $display("FAIL midrst_aborted got=%0d want=0", ev_cyc.size()); end
        send_frame(7'h01, good_pbit(7'h01, 1'b1), 1'b1, 1'b1, t0);
        rxd = 1'b1;
        repeat (2 * N) @(negedge clk);
        total++; if (ev_cyc.size() !== 1) begin bad++; $display("FAIL midrst_next_count got=%0d want=1", ev_cyc.size()); end
        if (ev_cyc.size() > 0) begin
            total++; if (ev_din[0] !== 7'h01) begin bad++; $display("FAIL midrst_next_din got=%h want=01", ev_din[0]); end
            total++; if ((ev_perr[0] | ev_ferr[0]) !== 1'b0) begin bad++; $display("FAIL midrst_next_flags got=%b%b want=00", ev_perr[0], ev_ferr[0]); end
        end
    endtask

    initial begin
        rst = 1'b0;
        rxd = 1'b1;
        p_s = 1'b1;
        @(negedge clk);
        test_reset();
        test_even_parity();
        test_odd_wrong();
        test_glitch();
        test_break();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
